vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/VESA raster timing generator. It is the next generation of our fixed 640x480 sync block.
//  Produces hsync/vsync with configurable porches, widths and polarity, plus pixel coordinates and an active flag.
//  Adds a pixel-clock enable, registered outputs, line/frame strobes and a vblank flag.
//  Sits between the clock divider and the pixel renderer/framebuffer reader.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  H_POL     0    hsync asserted level (0 = active-low)
//  V_POL     0    vsync asserted level (0 = active-low)
//  COORD_W   10   width of x/y; must hold max(H_TOTAL,V_TOTAL)-1
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        synchronous, active-low reset
//  pix_en       in   1        pixel-clock enable; timing advances only when high
//  hSync        out  1        horizontal sync, polarity per H_POL
//  vSync        out  1        vertical sync, polarity per V_POL
//  active       out  1        current pixel inside visible area
//  vblank       out  1        current line >= V_ACTIVE
//  x            out  COORD_W  pixel column; 0 outside active columns
//  y            out  COORD_W  pixel row; 0 outside active lines
//  line_start   out  1        1-clk strobe: pixel (0, any line) emitted
//  frame_start  out  1        1-clk strobe: pixel (0,0) emitted
// BEHAVIOUR
//  Totals and counters:
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
//   - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
//   - h_cnt counts 0..H_TOTAL-1; v_cnt counts 0..V_TOTAL-1. Both hold the NEXT position to emit.
//  Line layout (h or v): ACTIVE [0,ACT) -> FP -> SYNC -> BP -> wrap to 0. No off-by-one extra count.
//  Reset (reset_n=0 at posedge clk):
//   - h_cnt=v_cnt=0; x=y=0.
//   - active=0, vblank=0, line_start=0, frame_start=0.
//   - hSync=~H_POL, vSync=~V_POL (deasserted).
//   - Reset has priority over pix_en. Reset mid-frame restarts at (0,0) on the first pix_en after release.
//  On each clk with pix_en=1:
//   - Output registers load the decode of (h_cnt,v_cnt); latency = 1 clk from the pix_en edge.
//   - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
//   - v_cnt wraps to 0 only when h_cnt wraps while v_cnt = V_TOTAL-1.
//  Decode:
//   - hSync=H_POL while h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - vSync likewise on v.
//   - active=(h<H_ACTIVE)&&(v<V_ACTIVE); vblank=(v>=V_ACTIVE).
//   - x=h when h<H_ACTIVE else 0; y=v when v<V_ACTIVE else 0.
//  pix_en=0:
//   - Counters and level outputs hold.
//   - line_start/frame_start drop to 0 (strobes are exactly one clk wide regardless of pix_en duty).
//  Strobes: line_start on every line incl. blanking lines; frame_start coincides with line_start at v=0.
//  Legality: every porch/sync/active param >= 1; elaboration-time $error if a total exceeds 2**COORD_W.
// STRUCTURE
//  Package vga_timing_pkg:
//   - enum axis_phase_t {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP}.
//   - struct vga_timing_t with the 8 length fields.
//   - localparams VGA_640x480_60: 640/16/96/48, 480/10/2/33, neg/neg.
//   - localparams SVGA_800x600_60: 800/40/128/88, 600/1/4/23, pos/pos.
//  Sub-module vga_axis_ctr, instanced twice (horizontal, vertical):
//   - Ports: inc, wrap_out, count, phase.
//   - Phase FSM: ACTIVE->FP->SYNC->BP->ACTIVE.
//   - The horizontal instance's wrap_out drives the vertical instance's inc.
// TESTING
//  T1 defaults, pix_en=1, run 2 frames:
//   - hSync low exactly 96 clks per 800-clk line, starting 656 clks after line_start.
//   - vSync low exactly 2 lines.
//   - frame period 420000 clks.
//  T2 first pixel:
//   - reset_n low 3 clks, then high.
//   - Clk after first pix_en: x=0, y=0, active=1, frame_start=1, line_start=1.
//   - Next clk: x=1, frame_start=0.
//  T3 pix_en every 4th clk:
//   - Strobes each 1 clk wide.
//   - x steps 0,1,2... once per enable and holds between enables.
//   - Line = 3200 clks.
//  T4 wrap:
//   - At h=799, v=524 emitted, next emitted is (0,0) with frame_start=1.
//   - Line 480: vblank=1, active=0, y=0.
//  T5 reset mid-line at (x=300, y=200), pix_en held high:
//   - Outputs return to reset values next clk.
//   - After release, emission restarts at (0,0).
//  T6 SVGA_800x600_60 params:
//   - hSync high for 128 clks starting at h=840.
//   - H_TOTAL=1056, V_TOTAL=628.
//   - vSync high 4 lines.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and standard mode presets for the VGA raster timing generator.
package vga_timing_pkg;

   // Region of a line (horizontal) or frame (vertical) the counter is in
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } axis_phase_t;

   // Lengths of every region on both axes
   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } vga_timing_t;

   localparam vga_timing_t VGA_640x480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
   };
   localparam bit VGA_640x480_60_H_POL = 1'b0;
   localparam bit VGA_640x480_60_V_POL = 1'b0;

   localparam vga_timing_t SVGA_800x600_60 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
   };
   localparam bit SVGA_800x600_60_H_POL = 1'b1;
   localparam bit SVGA_800x600_60_V_POL = 1'b1;

   // Total positions on one axis
   function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: position counter 0..TOTAL-1 with a phase FSM tracking
// ACTIVE -> FP -> SYNC -> BP. count/phase describe the next position to emit.
module vga_axis_ctr
   import vga_timing_pkg::*;
#(
   parameter int ACT  = 640,
   parameter int FP   = 16,
   parameter int SYNC = 96,
   parameter int BP   = 48,
   parameter int W    = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inc,
   output logic        wrap_out,
   output logic [W-1:0] count,
   output axis_phase_t phase
);

   localparam int TOTAL = axis_total(ACT, FP, SYNC, BP);
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACT - 1);
   localparam logic [W-1:0] FP_END   = W'(ACT + FP - 1);
   localparam logic [W-1:0] SYNC_END = W'(ACT + FP + SYNC - 1);

   if (ACT < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_len_chk
      $error("vga_axis_ctr: every region length must be at least 1");
   end

   // Combinational so the next axis advances on the same enable as the wrap
   assign wrap_out = inc && (count == LAST);

   // Counter and phase FSM step together on every increment
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
         phase <= PH_ACTIVE;
      end else if (inc) begin
         count <= (count == LAST) ? '0 : count + W'(1);
         case (phase)
            PH_ACTIVE: if (count == ACT_END)  phase <= PH_FP;
            PH_FP:     if (count == FP_END)   phase <= PH_SYNC;
            PH_SYNC:   if (count == SYNC_END) phase <= PH_BP;
            PH_BP:     if (count == LAST)     phase <= PH_ACTIVE;
            default:                          phase <= PH_ACTIVE;
         endcase
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator with pixel-clock enable.
// All outputs are registered and describe the pixel emitted on the last enable.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_640x480_60.h_active,
   parameter int H_FP     = VGA_640x480_60.h_fp,
   parameter int H_SYNC   = VGA_640x480_60.h_sync,
   parameter int H_BP     = VGA_640x480_60.h_bp,
   parameter int V_ACTIVE = VGA_640x480_60.v_active,
   parameter int V_FP     = VGA_640x480_60.v_fp,
   parameter int V_SYNC   = VGA_640x480_60.v_sync,
   parameter int V_BP     = VGA_640x480_60.v_bp,
   parameter bit H_POL    = VGA_640x480_60_H_POL,
   parameter bit V_POL    = VGA_640x480_60_V_POL,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_en,
   output logic               hSync,
   output logic               vSync,
   output logic               active,
   output logic               vblank,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_width_chk
      $error("vga_timing_gen: COORD_W too narrow for the line or frame total");
   end

   logic               h_wrap;
   logic               v_wrap;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   axis_phase_t        h_phase;
   axis_phase_t        v_phase;
   // Set when the next emitted pixel is (0,0): after reset and after the last pixel of a frame
   logic               frame_pend;

   vga_axis_ctr #(
      .ACT  (H_ACTIVE),
      .FP   (H_FP),
      .SYNC (H_SYNC),
      .BP   (H_BP),
      .W    (COORD_W)
   ) u_h_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (pix_en),
      .wrap_out (h_wrap),
      .count    (h_cnt),
      .phase    (h_phase)
   );

   vga_axis_ctr #(
      .ACT  (V_ACTIVE),
      .FP   (V_FP),
      .SYNC (V_SYNC),
      .BP   (V_BP),
      .W    (COORD_W)
   ) u_v_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (h_wrap),
      .wrap_out (v_wrap),
      .count    (v_cnt),
      .phase    (v_phase)
   );

   // Register the decode of the current position; strobes last exactly one clk
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hSync       <= ~H_POL;
         vSync       <= ~V_POL;
         active      <= 1'b0;
         vblank      <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_pend  <= 1'b1;
      end else if (pix_en) begin
         hSync       <= (h_phase == PH_SYNC) ? H_POL : ~H_POL;
         vSync       <= (v_phase == PH_SYNC) ? V_POL : ~V_POL;
         active      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
         vblank      <= (v_phase != PH_ACTIVE);
         x           <= (h_phase == PH_ACTIVE) ? h_cnt : '0;
         y           <= (v_phase == PH_ACTIVE) ? v_cnt : '0;
         line_start  <= (h_cnt == '0);
         frame_start <= frame_pend;
         frame_pend  <= v_wrap;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule
